// File: rtl/map_pkg.sv
// Shared widths, header constants and FSM state encoding for the map frame serializer.
package map_pkg;
  localparam int ROW_W         = 38;
  localparam int N_ROWS        = 38;
  localparam int HDR_VALID_BIT = 37;
  localparam logic [15:0] HDR_MARKER = 16'hAAAA;
  localparam int IDX_W         = 6;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
endpackage

// File: rtl/map_row_buffer.sv
// Frame buffer: all words written in one cycle, one word read by index,
// plus a per-word non-zero flag vector for the zero-suppression search.
module map_row_buffer #(
  parameter int N_WORDS = 39,
  parameter int WORD_W  = 38
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_wr,
  input  logic [N_WORDS-1:0][WORD_W-1:0] i_wdata,
  input  logic [map_pkg::IDX_W-1:0]      i_ridx,
  output logic [WORD_W-1:0]              o_rdata,
  output logic [N_WORDS-1:0]             o_nz
);
  import map_pkg::*;

  logic [WORD_W-1:0] r_mem [N_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned w = 0; w < N_WORDS; w++) r_mem[w] <= '0;
    end else if (i_wr) begin
      for (int unsigned w = 0; w < N_WORDS; w++) r_mem[w] <= i_wdata[w];
    end
  end

  assign o_rdata = (i_ridx < IDX_W'(N_WORDS)) ? r_mem[i_ridx] : '0;

  always_comb begin
    o_nz = '0;
    for (int unsigned w = 0; w < N_WORDS; w++) o_nz[w] = |r_mem[w];
  end
endmodule

// File: rtl/map_frame_serializer.sv
// Captures a header + N_ROWS bitmap rows and streams them out one word per transfer.
// Optional macro MAP_SERIALIZER_ZERO_SUPPRESS_EN skips all-zero row words.
module map_frame_serializer #(
  parameter int N_ROWS     = map_pkg::N_ROWS,
  parameter int DROP_CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [map_pkg::ROW_W-1:0]   array_header,
  input  logic [map_pkg::ROW_W-1:0]   array_in00, array_in01, array_in02, array_in03,
  input  logic [map_pkg::ROW_W-1:0]   array_in04, array_in05, array_in06, array_in07,
  input  logic [map_pkg::ROW_W-1:0]   array_in08, array_in09, array_in10, array_in11,
  input  logic [map_pkg::ROW_W-1:0]   array_in12, array_in13, array_in14, array_in15,
  input  logic [map_pkg::ROW_W-1:0]   array_in16, array_in17, array_in18, array_in19,
  input  logic [map_pkg::ROW_W-1:0]   array_in20, array_in21, array_in22, array_in23,
  input  logic [map_pkg::ROW_W-1:0]   array_in24, array_in25, array_in26, array_in27,
  input  logic [map_pkg::ROW_W-1:0]   array_in28, array_in29, array_in30, array_in31,
  input  logic [map_pkg::ROW_W-1:0]   array_in32, array_in33, array_in34, array_in35,
  input  logic [map_pkg::ROW_W-1:0]   array_in36, array_in37,
  output logic [map_pkg::ROW_W-1:0]   out_data,
  output logic [map_pkg::IDX_W-1:0]   out_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic [DROP_CNT_W-1:0]       drop_cnt
);
  import map_pkg::*;

  localparam int N_WORDS = N_ROWS + 1;

  state_t                         r_state, w_state_nxt;
  logic [IDX_W-1:0]               r_idx, w_idx_nxt, w_idx_succ;
  logic [DROP_CNT_W-1:0]          r_drop_cnt;
  logic [37:0][ROW_W-1:0]         w_rows;
  logic [N_WORDS-1:0][ROW_W-1:0]  w_wdata;
  logic [ROW_W-1:0]               w_rdata;
  logic [N_WORDS-1:0]             w_nz;
  logic                           w_busy, w_xfer, w_last, w_frame_valid, w_capture, w_drop;

  assign w_rows = {array_in37, array_in36, array_in35, array_in34, array_in33, array_in32,
                   array_in31, array_in30, array_in29, array_in28, array_in27, array_in26,
                   array_in25, array_in24, array_in23, array_in22, array_in21, array_in20,
                   array_in19, array_in18, array_in17, array_in16, array_in15, array_in14,
                   array_in13, array_in12, array_in11, array_in10, array_in09, array_in08,
                   array_in07, array_in06, array_in05, array_in04, array_in03, array_in02,
                   array_in01, array_in00};

  always_comb begin
    w_wdata    = '0;
    w_wdata[0] = array_header;
    for (int unsigned r = 0; r < N_ROWS; r++) w_wdata[r+1] = w_rows[r];
  end

  map_row_buffer #(
    .N_WORDS (N_WORDS),
    .WORD_W  (ROW_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst),
    .i_wr    (w_capture),
    .i_wdata (w_wdata),
    .i_ridx  (r_idx),
    .o_rdata (w_rdata),
    .o_nz    (w_nz)
  );

  assign w_busy        = (r_state == SEND);
  assign w_xfer        = w_busy & out_ready;
  assign w_frame_valid = array_header[HDR_VALID_BIT];
  // A new frame can replace the held one only on the cycle its final word leaves.
  assign w_capture     = w_frame_valid & (~w_busy | (w_xfer & w_last));
  assign w_drop        = w_frame_valid & ~w_capture;

`ifdef MAP_SERIALIZER_ZERO_SUPPRESS_EN
  logic w_found;
  always_comb begin
    w_idx_succ = r_idx;
    w_found    = 1'b0;
    for (int unsigned k = 1; k <= N_ROWS; k++) begin
      if (!w_found && (IDX_W'(k) > r_idx) && w_nz[k]) begin
        w_found    = 1'b1;
        w_idx_succ = IDX_W'(k);
      end
    end
    w_last = ~w_found;
  end
`else
  logic w_unused_nz;
  assign w_unused_nz = |w_nz;
  assign w_idx_succ  = r_idx + 1'b1;
  assign w_last      = (r_idx == IDX_W'(N_ROWS));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_capture) begin
          w_state_nxt = SEND;
          w_idx_nxt   = '0;
        end
      end
      SEND: begin
        if (w_capture) begin
          w_idx_nxt = '0;
        end else if (w_xfer) begin
          if (w_last) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = w_idx_succ;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign out_valid = w_busy;
  assign out_data  = w_busy ? w_rdata : '0;
  assign out_idx   = w_busy ? r_idx : '0;
  assign out_last  = w_busy & w_last;
  assign busy      = w_busy;
  assign drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_map_frame_serializer.sv
// Directed bench for map_frame_serializer; zero-suppression cases build only
// when MAP_SERIALIZER_ZERO_SUPPRESS_EN is defined.
module tb_map_frame_serializer;
  localparam logic [37:0] HDR  = 38'h20_0104_AAAA;
  localparam logic [37:0] HDR2 = 38'h20_0000_5555;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [37:0] array_header = '0;
  logic [37:0] rows [38];
  logic        out_ready = 1'b1;
  logic [37:0] out_data;
  logic [5:0]  out_idx;
  logic        out_valid, out_last, busy;
  logic [7:0]  drop_cnt;

  logic [37:0] m_hdr;
  logic [37:0] m_rows [38];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  map_frame_serializer #(.N_ROWS(38), .DROP_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .array_header(array_header),
    .array_in00(rows[0]),  .array_in01(rows[1]),  .array_in02(rows[2]),  .array_in03(rows[3]),
    .array_in04(rows[4]),  .array_in05(rows[5]),  .array_in06(rows[6]),  .array_in07(rows[7]),
    .array_in08(rows[8]),  .array_in09(rows[9]),  .array_in10(rows[10]), .array_in11(rows[11]),
    .array_in12(rows[12]), .array_in13(rows[13]), .array_in14(rows[14]), .array_in15(rows[15]),
    .array_in16(rows[16]), .array_in17(rows[17]), .array_in18(rows[18]), .array_in19(rows[19]),
    .array_in20(rows[20]), .array_in21(rows[21]), .array_in22(rows[22]), .array_in23(rows[23]),
    .array_in24(rows[24]), .array_in25(rows[25]), .array_in26(rows[26]), .array_in27(rows[27]),
    .array_in28(rows[28]), .array_in29(rows[29]), .array_in30(rows[30]), .array_in31(rows[31]),
    .array_in32(rows[32]), .array_in33(rows[33]), .array_in34(rows[34]), .array_in35(rows[35]),
    .array_in36(rows[36]), .array_in37(rows[37]),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [37:0] row_val(input int pat, input int r);
    case (pat)
      0:       return 38'(r + 1);
      1:       return 38'((r + 1) << 8) | 38'h1;
      2:       return (r >= 11 && r <= 18) ? 38'(r + 1) : 38'h0;
      default: return 38'h0;
    endcase
  endfunction

  task automatic apply_pat(input int pat);
    for (int r = 0; r < 38; r++) rows[r] = row_val(pat, r);
  endtask

  task automatic set_model(input logic [37:0] hdr, input int pat);
    m_hdr = hdr;
    for (int r = 0; r < 38; r++) m_rows[r] = row_val(pat, r);
  endtask

  // Present a frame-valid header for one cycle; returns at the negedge after capture.
  task automatic send_pulse(input logic [37:0] hdr, input int pat);
    array_header = hdr;
    apply_pat(pat);
    set_model(hdr, pat);
    @(posedge clk);
    @(negedge clk);
    array_header = '0;
  endtask

  // Walk the expected word list of the model frame, optionally toggling ready and
  // injecting one extra frame-valid pulse while word number pulse_at is on the bus.
  task automatic run_stream(input bit toggle, input int pulse_at,
                            input logic [37:0] pulse_hdr, input int pulse_pat);
    int  exp_q[$];
    int  ptr = 0;
    int  cyc = 0;
    int  limit;
    bit  rdy;
    bit  pulsed = 1'b0;
    logic [37:0] w;
    exp_q.push_back(0);
    for (int r = 0; r < 38; r++) begin
`ifdef MAP_SERIALIZER_ZERO_SUPPRESS_EN
      if (m_rows[r] != 38'h0) exp_q.push_back(r + 1);
`else
      exp_q.push_back(r + 1);
`endif
    end
    limit = 4 * exp_q.size() + 10;
    while (ptr < exp_q.size() && cyc < limit) begin
      rdy = toggle ? cyc[0] : 1'b1;
      out_ready = rdy;
      if (ptr == pulse_at && !pulsed) begin
        array_header = pulse_hdr;
        if (pulse_pat >= 0) apply_pat(pulse_pat);
        pulsed = 1'b1;
      end else begin
        array_header = '0;
      end
      w = (exp_q[ptr] == 0) ? m_hdr : m_rows[exp_q[ptr] - 1];
      check("stream_valid", 64'(out_valid), 64'(1));
      check("stream_idx",   64'(out_idx),   64'(exp_q[ptr]));
      check("stream_data",  64'(out_data),  64'(w));
      check("stream_last",  64'(out_last),  64'(ptr == exp_q.size() - 1));
      @(posedge clk);
      @(negedge clk);
      if (rdy) ptr++;
      cyc++;
    end
    array_header = '0;
    out_ready = 1'b1;
    check("stream_cycles", 64'(cyc), 64'(toggle ? 2 * exp_q.size() : exp_q.size()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    apply_pat(3);
    set_model('0, 3);
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data",  64'(out_data),  64'(0));
    check("rst_idx",   64'(out_idx),   64'(0));
    check("rst_last",  64'(out_last),  64'(0));
    check("rst_busy",  64'(busy),      64'(0));
    check("rst_drop",  64'(drop_cnt),  64'(0));
    rst = 1'b1;
    @(negedge clk);

    // Full-rate frame, then idle one cycle after the last word
    send_pulse(HDR, 0);
    check("hdr_first", 64'(out_data), 64'h20_0104_AAAA);
    run_stream(1'b0, -1, '0, -1);
    check("t1_busy",  64'(busy),      64'(0));
    check("t1_valid", 64'(out_valid), 64'(0));
    check("t1_data",  64'(out_data),  64'(0));
    check("t1_last",  64'(out_last),  64'(0));

    // Ready toggling 0/1: each word held two cycles
    send_pulse(HDR, 0);
    run_stream(1'b1, -1, '0, -1);
    check("t2_valid", 64'(out_valid), 64'(0));

    // Pulse mid-frame is dropped, frame continues intact
    send_pulse(HDR, 0);
    run_stream(1'b0, 10, HDR2, 1);
    check("t3_drop", 64'(drop_cnt), 64'(1));

    // Pulse on final transfer: back-to-back frame, no drop
    send_pulse(HDR, 0);
    run_stream(1'b0, 38, HDR2, 1);
    check("t4_nogap_valid", 64'(out_valid), 64'(1));
    check("t4_nogap_idx",   64'(out_idx),   64'(0));
    check("t4_nogap_data",  64'(out_data),  64'h20_0000_5555);
    set_model(HDR2, 1);
    run_stream(1'b0, -1, '0, -1);
    check("t4_drop", 64'(drop_cnt), 64'(1));

    // 300 drops saturate the counter at 255
    send_pulse(HDR, 0);
    out_ready = 1'b0;
    array_header = HDR2;
    repeat (253) begin @(posedge clk); @(negedge clk); end
    check("t5_drop_254", 64'(drop_cnt), 64'(254));
    repeat (47) begin @(posedge clk); @(negedge clk); end
    check("t5_drop_sat", 64'(drop_cnt), 64'(255));
    array_header = '0;
    check("t5_hold_idx", 64'(out_idx), 64'(0));
    run_stream(1'b0, -1, '0, -1);
    check("t5_drop_end", 64'(drop_cnt), 64'(255));

    // Reset in the middle of a frame
    send_pulse(HDR, 0);
    out_ready = 1'b1;
    repeat (20) begin @(posedge clk); @(negedge clk); end
    check("t6_pre_idx", 64'(out_idx), 64'(20));
    rst = 1'b0;
    #1;
    check("t6_valid", 64'(out_valid), 64'(0));
    check("t6_data",  64'(out_data),  64'(0));
    check("t6_idx",   64'(out_idx),   64'(0));
    check("t6_last",  64'(out_last),  64'(0));
    check("t6_busy",  64'(busy),      64'(0));
    check("t6_drop",  64'(drop_cnt),  64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_abandon", 64'(out_valid), 64'(0));
    send_pulse(HDR2, 1);
    run_stream(1'b0, -1, '0, -1);
    check("t6_end_valid", 64'(out_valid), 64'(0));

`ifdef MAP_SERIALIZER_ZERO_SUPPRESS_EN
    // Only rows 11..18 non-zero: words 0,12..19
    send_pulse(HDR, 2);
    run_stream(1'b0, -1, '0, -1);
    // All rows zero: single header word flagged last
    send_pulse(HDR, 3);
    check("zs_hdr_idx",  64'(out_idx),  64'(0));
    check("zs_hdr_last", 64'(out_last), 64'(1));
    run_stream(1'b0, -1, '0, -1);
    check("zs_end_valid", 64'(out_valid), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
